// File: rtl/bus_packer_pkg.sv
// bus_packer_pkg: shared state encoding and default bus geometry for bus_packer.
package bus_packer_pkg;

  localparam int DEFAULT_BUS_SIZE  = 16;
  localparam int DEFAULT_WORD_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/bus_packer.sv
// bus_packer: packs WORD_SIZE-bit words LSB-first into a registered BUS_SIZE-bit bus.
// Optional feature: define BUS_PACKER_PARITY_EN to add a registered even-parity output.
module bus_packer
  import bus_packer_pkg::*;
#(
  parameter int BUS_SIZE  = DEFAULT_BUS_SIZE,
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 in_ready,
  output logic [BUS_SIZE-1:0]  data_bus,
  output logic [WORD_NUM-1:0]  control_out,
  output logic                 bus_valid,
  output logic                 error
`ifdef BUS_PACKER_PARITY_EN
  ,
  output logic                 parity_out
`endif
);

  localparam int CW = $clog2(WORD_NUM + 1);

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [BUS_SIZE-1:0] bus_next;
  logic [WORD_NUM-1:0] ctrl_next;
  logic                accept;

  assign in_ready  = (state != SEND);
  assign bus_valid = (state == SEND);
  assign accept    = valid_in && in_ready;

  // The bus register doubles as the fill buffer; a new bus starts from all-zero slots.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bus_next   = data_bus;
    ctrl_next  = control_out;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          if (state == IDLE) begin
            bus_next  = '0;
            ctrl_next = '0;
          end
          for (int k = 0; k < WORD_NUM; k++) begin
            if (cnt == CW'(k)) begin
              bus_next[k*WORD_SIZE +: WORD_SIZE] = data_in;
              ctrl_next[k] = 1'b1;
            end
          end
          cnt_next = cnt + CW'(1);
        end
        if (accept && (cnt_next == CW'(WORD_NUM))) begin
          state_next = SEND;
        end else if (flush && (accept || (state == FILL))) begin
          state_next = SEND;
        end else if (accept) begin
          state_next = FILL;
        end
      end
      SEND: begin
        if (out_ready) begin
          state_next = IDLE;
          cnt_next   = '0;
          ctrl_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        ctrl_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      data_bus    <= '0;
      control_out <= '0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      data_bus    <= bus_next;
      control_out <= ctrl_next;
      error       <= error | (valid_in & ~in_ready);
    end
  end

`ifdef BUS_PACKER_PARITY_EN
  // Parity tracks the value being loaded so it lands on the same edge as data_bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_out <= 1'b0;
    end else begin
      parity_out <= ^bus_next;
    end
  end
`endif

endmodule

// File: tb/tb_bus_packer.sv
// tb_bus_packer: directed and randomized checks of bus_packer against a queue-based model.
// Build with BUS_PACKER_PARITY_EN defined to also check parity_out.
module tb_bus_packer;

  localparam int BUS_SIZE  = 16;
  localparam int WORD_SIZE = 4;
  localparam int WORD_NUM  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [WORD_SIZE-1:0] data_in = '0;
  logic                 valid_in = 1'b0;
  logic                 flush = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic [BUS_SIZE-1:0]  data_bus;
  logic [WORD_NUM-1:0]  control_out;
  logic                 bus_valid;
  logic                 error;
`ifdef BUS_PACKER_PARITY_EN
  logic                 parity_out;
`endif

  int checks = 0;
  int errors = 0;

  // Model: words collected for the current bus, whether it is being offered, sticky error.
  logic [WORD_SIZE-1:0] m_q[$];
  bit                   m_sending;
  bit                   m_err;

  bus_packer #(
    .BUS_SIZE (BUS_SIZE),
    .WORD_SIZE(WORD_SIZE),
    .WORD_NUM (WORD_NUM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .flush      (flush),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .data_bus   (data_bus),
    .control_out(control_out),
    .bus_valid  (bus_valid),
    .error      (error)
`ifdef BUS_PACKER_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [BUS_SIZE-1:0] modelBus();
    logic [BUS_SIZE-1:0] b = '0;
    for (int k = 0; k < m_q.size(); k++) begin
      logic [BUS_SIZE-1:0] w = BUS_SIZE'(m_q[k]);
      b = b | (w << (k * WORD_SIZE));
    end
    return b;
  endfunction

  function automatic logic [WORD_NUM-1:0] modelCtrl();
    return WORD_NUM'((1 << m_q.size()) - 1);
  endfunction

  task automatic modelStep(input logic v, input logic [WORD_SIZE-1:0] d, input logic f, input logic r);
    if (v && m_sending) m_err = 1'b1;
    if (m_sending) begin
      if (r) begin
        m_sending = 1'b0;
        m_q.delete();
      end
    end else begin
      if (v) m_q.push_back(d);
      if (m_q.size() == WORD_NUM || (f && m_q.size() > 0)) m_sending = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("bus_valid", bus_valid, m_sending);
    checkOutput("in_ready", in_ready, !m_sending);
    checkOutput("error", error, m_err);
    checkOutput("control_out", control_out, modelCtrl());
    if (m_sending) begin
      checkOutput("data_bus", data_bus, modelBus());
`ifdef BUS_PACKER_PARITY_EN
      checkOutput("parity_out", parity_out, ^modelBus());
`endif
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WORD_SIZE-1:0] d, input logic f, input logic r);
    valid_in  = v;
    data_in   = d;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    modelStep(v, d, f, r);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    m_q.delete();
    m_sending = 1'b0;
    m_err     = 1'b0;
    #1;
    reset = 1'b0;
    checkOutput("rst_data_bus", data_bus, 0);
    checkOutput("rst_control", control_out, 0);
    checkOutput("rst_bus_valid", bus_valid, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef BUS_PACKER_PARITY_EN
    checkOutput("rst_parity", parity_out, 0);
`endif
  endtask

  initial begin
    doReset();

    // Full bus with immediate acceptance.
    applyStimulus(1, 4'h0, 0, 1);
    applyStimulus(1, 4'hA, 0, 1);
    applyStimulus(1, 4'hB, 0, 1);
    applyStimulus(1, 4'hF, 0, 1);
    checkOutput("full_bus", data_bus, 16'hFBA0);
    checkOutput("full_ctrl", control_out, 4'b1111);
    checkOutput("full_valid", bus_valid, 1);
`ifdef BUS_PACKER_PARITY_EN
    checkOutput("full_parity", parity_out, 1);
`endif
    applyStimulus(0, 4'h0, 0, 1);
    checkOutput("full_one_cycle", bus_valid, 0);

    // Flush with the last word accepted in the same cycle.
    applyStimulus(1, 4'h3, 0, 1);
    applyStimulus(1, 4'hA, 1, 1);
    checkOutput("flush_bus", data_bus, 16'h00A3);
    checkOutput("flush_ctrl", control_out, 4'b0011);
    applyStimulus(0, 4'h0, 0, 1);

    // Flush while empty must not produce a bus.
    applyStimulus(0, 4'h0, 1, 1);
    checkOutput("idle_flush", bus_valid, 0);

    // Backpressure: bus held until the handshake.
    applyStimulus(1, 4'h9, 0, 0);
    applyStimulus(1, 4'hA, 0, 0);
    applyStimulus(1, 4'hB, 0, 0);
    applyStimulus(1, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'h0, 0, 0);
      checkOutput("held_bus", data_bus, 16'hFBA9);
    end
    applyStimulus(0, 4'h0, 0, 1);
    checkOutput("bp_idle_ready", in_ready, 1);

    // Reset in the middle of a fill discards the partial bus.
    applyStimulus(1, 4'h7, 0, 1);
    applyStimulus(1, 4'h8, 0, 1);
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 0);
    checkOutput("after_rst_bus", data_bus, 16'h4321);
    checkOutput("after_rst_ctrl", control_out, 4'b1111);

    // Overflow during SEND: sticky error, held bus unchanged.
    applyStimulus(1, 4'h5, 0, 0);
    checkOutput("ovf_error", error, 1);
    checkOutput("ovf_bus", data_bus, 16'h4321);
    applyStimulus(0, 4'h0, 0, 1);
    applyStimulus(1, 4'h2, 0, 1);
    checkOutput("ovf_sticky", error, 1);
    doReset();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 4'($urandom),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_packer.md
BUS_PACKER -- requirements
Module: bus_packer

Interface
- REQ-001 SHALL have parameter BUS_SIZE, default 16: width of the output bus in bits.
- REQ-002 SHALL have parameter WORD_SIZE, default 4: width of one input word in bits.
- REQ-003 SHALL have parameter WORD_NUM, default BUS_SIZE/WORD_SIZE: number of words per bus.
- REQ-004 SHALL have port clk  input  1: single clock, all logic on its rising edge.
- REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
- REQ-006 SHALL have port data_in  input  WORD_SIZE: word to pack.
- REQ-007 SHALL have port valid_in  input  1: data_in valid this cycle.
- REQ-008 SHALL have port flush  input  1: send a partially filled bus.
- REQ-009 SHALL have port out_ready  input  1: downstream accepts data_bus.
- REQ-010 SHALL have port in_ready  output  1: packer accepts a word this cycle.
- REQ-011 SHALL have port data_bus  output  BUS_SIZE: packed bus, registered.
- REQ-012 SHALL have port control_out  output  WORD_NUM: per-slot filled flags, registered.
- REQ-013 SHALL have port bus_valid  output  1: data_bus/control_out valid.
- REQ-014 SHALL have port error  output  1: sticky protocol-violation flag.

Function
- REQ-015 SHALL implement FSM states IDLE (0 words), FILL (1..WORD_NUM-1 words), SEND (bus_valid=1).
- REQ-016 SHALL accept a word when valid_in & in_ready; in_ready=1 in IDLE and FILL, 0 in SEND.
- REQ-017 SHALL place word k (0-based arrival order) in data_bus[k*WORD_SIZE +: WORD_SIZE], LSB-first, and set control_out[k].
- REQ-018 SHALL clear unfilled slots to zero, with their control_out bits at 0.
- REQ-019 SHALL move to SEND the cycle after the WORD_NUM-th word is accepted (1-cycle latency to bus_valid).
- REQ-020 SHALL move FILL->SEND on flush; if valid_in is also accepted that cycle, SHALL include that word first.
- REQ-021 SHALL ignore flush in IDLE when no word is accepted (no empty bus ever sent).
- REQ-022 SHALL hold data_bus, control_out and bus_valid stable in SEND while out_ready=0.
- REQ-023 SHALL complete a transfer on bus_valid & out_ready, then enter IDLE next cycle with control_out cleared and in_ready=1.
- REQ-024 SHALL set error when valid_in=1 while in_ready=0, hold it until reset, and drop that word.
- REQ-025 SHALL keep data_bus bits outside bus_valid at last value (don't-care for the consumer).

Reset
- REQ-026 SHALL, on reset, set state IDLE, data_bus=0, control_out=0, bus_valid=0, error=0, in_ready=1 on the next edge.
- REQ-027 SHALL let reset override every other input, including during FILL or SEND; partial or pending buses are discarded.

Configuration
- REQ-028 SHALL, with BUS_PACKER_PARITY_EN defined, add output parity_out (1 bit): even-parity bit over data_bus, registered with it, 0 on reset.
- REQ-029 SHALL, without BUS_PACKER_PARITY_EN, omit parity_out and its logic; all other behaviour identical.

Structure
- REQ-030 SHALL put the state enum typedef and default BUS_SIZE/WORD_SIZE constants in shared package bus_packer_pkg.
- REQ-031 SHALL be a single module with no sub-module; the parity is inline logic.

Verification
- REQ-032 SHALL cover a full bus: words 0x0,0xA,0xB,0xF on 4 cycles with out_ready=1 -> next cycle data_bus=16'hFBA0, control_out=4'b1111, bus_valid=1 for 1 cycle.
- REQ-033 SHALL cover flush: 0x3, then 0xA with flush=1 -> data_bus=16'h00A3, control_out=4'b0011.
- REQ-034 SHALL cover backpressure: full bus 16'hFBA9 with out_ready=0 for 3 cycles -> bus held 4 cycles, IDLE after the handshake.
- REQ-035 SHALL cover overflow: valid_in=1 during SEND -> error=1 and stays 1 until reset; the held bus is unchanged.
- REQ-036 SHALL cover reset mid-fill: 2 words, then reset=1 for 1 cycle, then 4 words 0x1..0x4 -> data_bus=16'h4321, control_out=4'b1111.
- REQ-037 SHALL cover parity, with BUS_PACKER_PARITY_EN defined: data_bus=16'hFBA0 -> parity_out=1.
